// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle shift-add multiplier / restoring divider with HI/LO registers.
// Ports: clk, rst, start, op, RsData, RtData, hi_we, lo_we, wr_data -> busy, done, HiOut, LoOut.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MinInt = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, stateNext;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] accHi, accLo, opnd, rsRaw;
  logic [WIDTH-1:0] hiReg, loReg;
  logic             isDiv, negA, negB, divZero, divOvf;

  logic             accept, lastStep;
  logic             aNeg, bNeg;
  logic [WIDTH-1:0] rsMag, rtMag;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH+1:0] divDiff;
  logic [WIDTH-1:0] stepHi, stepLo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] resHi, resLo;

  assign accept   = start && (state != BUSY);
  assign lastStep = (count == CW'(WIDTH-1));
  assign busy     = (state == BUSY);
  assign done     = (state == DONE);
  assign HiOut    = hiReg;
  assign LoOut    = loReg;

  // Signed ops (op[0]==0) work on magnitudes; signs fix up the result.
  assign aNeg  = ~op[0] & RsData[WIDTH-1];
  assign bNeg  = ~op[0] & RtData[WIDTH-1];
  assign rsMag = aNeg ? -RsData : RsData;
  assign rtMag = bNeg ? -RtData : RtData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = BUSY;
      BUSY:    if (lastStep) stateNext = DONE;
      DONE:    stateNext = start ? BUSY : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // One iteration: accHi is the partial product / remainder,
  // accLo shifts out multiplier bits or dividend bits and collects quotient bits.
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
    divShift = {accHi, accLo[WIDTH-1]};
    divDiff  = {1'b0, divShift} - {2'b00, opnd};
    if (isDiv) begin
      if (divDiff[WIDTH+1]) begin
        stepHi = divShift[WIDTH-1:0];
        stepLo = {accLo[WIDTH-2:0], 1'b0};
      end else begin
        stepHi = divDiff[WIDTH-1:0];
        stepLo = {accLo[WIDTH-2:0], 1'b1};
      end
    end else begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], accLo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod = {stepHi, stepLo};
    if (!isDiv) begin
      if (negA ^ negB) prod = -prod;
      resHi = prod[2*WIDTH-1:WIDTH];
      resLo = prod[WIDTH-1:0];
    end else if (divZero) begin
      resHi = rsRaw;
      resLo = '1;
    end else if (divOvf) begin
      resHi = '0;
      resLo = MinInt;
    end else begin
      resHi = negA ? -stepHi : stepHi;
      resLo = (negA ^ negB) ? -stepLo : stepLo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      accHi   <= '0;
      accLo   <= '0;
      opnd    <= '0;
      rsRaw   <= '0;
      hiReg   <= '0;
      loReg   <= '0;
      isDiv   <= 1'b0;
      negA    <= 1'b0;
      negB    <= 1'b0;
      divZero <= 1'b0;
      divOvf  <= 1'b0;
    end else if (state == BUSY) begin
      accHi <= stepHi;
      accLo <= stepLo;
      count <= count + CW'(1);
      if (lastStep) begin
        hiReg <= resHi;
        loReg <= resLo;
      end
    end else if (accept) begin
      // Multiply: opnd = multiplicand, accLo = multiplier.
      // Divide:   opnd = divisor,      accLo = dividend.
      count   <= '0;
      accHi   <= '0;
      accLo   <= op[1] ? rsMag : rtMag;
      opnd    <= op[1] ? rtMag : rsMag;
      rsRaw   <= RsData;
      isDiv   <= op[1];
      negA    <= aNeg;
      negB    <= bNeg;
      divZero <= op[1] && (RtData == '0);
      divOvf  <= (op == 2'b10) && (RsData == MinInt) && (RtData == '1);
    end else begin
      if (hi_we) hiReg <= wr_data;
      if (lo_we) loReg <= wr_data;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit.
// Drives on negedge, samples on negedge (away from the rising edge).
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] RsData, RtData, wr_data;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] HiOut, LoOut;

  int total = 0;
  int bad = 0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .RsData(RsData), .RtData(RtData),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .HiOut(HiOut), .LoOut(LoOut)
  );

  always #5 clk = ~clk;

  // Caller is at a negedge; start is held across exactly one rising edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; RsData = a; RtData = b;
    @(posedge clk);
    #1;
    start = 1'b0; RsData = 32'hA5A5_5A5A; RtData = 32'h0F0F_F0F0;
  endtask

  // Counts busy cycles and records the cycle index of the done pulse (0 = never).
  task automatic waitDone(output int busyCnt, output int doneAt);
    int n;
    n = 0; busyCnt = 0; doneAt = 0;
    while (n < 40 && doneAt == 0) begin
      @(negedge clk);
      n++;
      if (busy) busyCnt++;
      if (done) doneAt = n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; op = 0; RsData = 0; RtData = 0;
    hi_we = 0; lo_we = 0; wr_data = 0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || HiOut !== 32'h0 || LoOut !== 32'h0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, HiOut, LoOut);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu_max();
    int n, busyCnt, doneAt;
    logic held;
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0; busyCnt = 0; doneAt = 0; held = 1'b1;
    while (n < 40 && doneAt == 0) begin
      @(negedge clk);
      n++;
      if (busy) begin
        busyCnt++;
        if (HiOut !== 32'h0 || LoOut !== 32'h0) held = 1'b0;
      end
      if (done) doneAt = n;
    end
    total++;
    if (!held) begin
      bad++;
      $display("FAIL multu_hold: partial result visible during busy, want hi=lo=0");
    end
    total++;
    if (busyCnt != 32 || doneAt != 33) begin
      bad++;
      $display("FAIL multu_timing: busy=%0d done_at=%0d want 32 33", busyCnt, doneAt);
    end
    total++;
    if (HiOut !== 32'hFFFF_FFFE || LoOut !== 32'h0000_0001) begin
      bad++;
      $display("FAIL multu_max: hi=%h lo=%h want fffffffe 00000001", HiOut, LoOut);
    end
  endtask

  task automatic test_ops();
    logic [1:0]  vo[8];
    logic [31:0] va[8], vb[8], vh[8], vl[8];
    int busyCnt, doneAt;
    vo[0]=2'b00; va[0]=32'hFFFF_FFFD; vb[0]=32'd7;        vh[0]=32'hFFFF_FFFF; vl[0]=32'hFFFF_FFEB;
    vo[1]=2'b00; va[1]=32'h8000_0000; vb[1]=32'h8000_0000; vh[1]=32'h4000_0000; vl[1]=32'h0;
    vo[2]=2'b10; va[2]=32'hFFFF_FFF9; vb[2]=32'd2;        vh[2]=32'hFFFF_FFFF; vl[2]=32'hFFFF_FFFD;
    vo[3]=2'b10; va[3]=32'd7;         vb[3]=32'hFFFF_FFFE; vh[3]=32'd1;        vl[3]=32'hFFFF_FFFD;
    vo[4]=2'b11; va[4]=32'd100;       vb[4]=32'd7;        vh[4]=32'd2;        vl[4]=32'd14;
    vo[5]=2'b11; va[5]=32'd100;       vb[5]=32'd0;        vh[5]=32'd100;      vl[5]=32'hFFFF_FFFF;
    vo[6]=2'b10; va[6]=32'h8000_0000; vb[6]=32'hFFFF_FFFF; vh[6]=32'h0;        vl[6]=32'h8000_0000;
    vo[7]=2'b10; va[7]=32'hFFFF_FFFB; vb[7]=32'd0;        vh[7]=32'hFFFF_FFFB; vl[7]=32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      launch(vo[i], va[i], vb[i]);
      waitDone(busyCnt, doneAt);
      total++;
      if (doneAt != 33 || HiOut !== vh[i] || LoOut !== vl[i]) begin
        bad++;
        $display("FAIL op%0d: done_at=%0d hi=%h lo=%h want 33 %h %h",
                 i, doneAt, HiOut, LoOut, vh[i], vl[i]);
      end
    end
  endtask

  task automatic test_ignore_busy_start();
    int n, doneAt;
    launch(2'b01, 32'd5, 32'd6);
    n = 0; doneAt = 0;
    while (n < 40 && doneAt == 0) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        start = 1'b1; op = 2'b01; RsData = 32'hFFFF_FFFF; RtData = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      if (done) doneAt = n;
    end
    start = 1'b0;
    total++;
    if (doneAt != 33 || HiOut !== 32'h0 || LoOut !== 32'd30) begin
      bad++;
      $display("FAIL ignore_start: done_at=%0d hi=%h lo=%h want 33 0 1e", doneAt, HiOut, LoOut);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL ignore_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int busyCnt, doneAt;
    launch(2'b01, 32'd3, 32'd4);
    waitDone(busyCnt, doneAt);
    total++;
    if (doneAt != 33 || LoOut !== 32'd12 || HiOut !== 32'd0) begin
      bad++;
      $display("FAIL b2b_first: done_at=%0d hi=%h lo=%h want 33 0 c", doneAt, HiOut, LoOut);
    end
    launch(2'b11, 32'd9, 32'd2);
    waitDone(busyCnt, doneAt);
    total++;
    if (busyCnt != 32 || doneAt != 33 || LoOut !== 32'd4 || HiOut !== 32'd1) begin
      bad++;
      $display("FAIL b2b_second: busy=%0d done_at=%0d hi=%h lo=%h want 32 33 1 4",
               busyCnt, doneAt, HiOut, LoOut);
    end
    @(negedge clk);
  endtask

  task automatic test_hilo_write();
    int n, busyCnt, doneAt;
    logic held;
    hi_we = 1'b1; wr_data = 32'h1234;
    @(posedge clk); #1; hi_we = 1'b0;
    @(negedge clk);
    total++;
    if (HiOut !== 32'h1234 || LoOut !== 32'd4) begin
      bad++;
      $display("FAIL mthi: hi=%h lo=%h want 1234 4", HiOut, LoOut);
    end
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h55;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    total++;
    if (HiOut !== 32'h55 || LoOut !== 32'h55) begin
      bad++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h want 55 55", HiOut, LoOut);
    end
    launch(2'b01, 32'd2, 32'd3);
    n = 0; doneAt = 0; held = 1'b1;
    while (n < 40 && doneAt == 0) begin
      @(negedge clk);
      n++;
      hi_we = (n == 3); wr_data = 32'hDEAD;
      if (busy && HiOut !== 32'h55) held = 1'b0;
      if (done) doneAt = n;
    end
    hi_we = 1'b0;
    total++;
    if (!held || doneAt != 33 || HiOut !== 32'h0 || LoOut !== 32'd6) begin
      bad++;
      $display("FAIL we_busy: held=%b done_at=%0d hi=%h lo=%h want 1 33 0 6",
               held, doneAt, HiOut, LoOut);
    end
    hi_we = 1'b1; wr_data = 32'h777;
    launch(2'b01, 32'd2, 32'd5);
    hi_we = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || HiOut !== 32'h0) begin
      bad++;
      $display("FAIL we_with_start: busy=%b hi=%h want 1 0", busy, HiOut);
    end
    waitDone(busyCnt, doneAt);
    total++;
    if (doneAt != 32 || LoOut !== 32'd10) begin
      bad++;
      $display("FAIL we_with_start_res: done_at=%0d lo=%h want 32 a", doneAt, LoOut);
    end
  endtask

  task automatic test_reset_abort();
    int busyCnt, doneAt;
    @(negedge clk);
    hi_we = 1'b1; wr_data = 32'h99;
    @(posedge clk); #1; hi_we = 1'b0;
    @(negedge clk);
    launch(2'b00, 32'd11, 32'd13);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || HiOut !== 32'h0 || LoOut !== 32'h0) begin
      bad++;
      $display("FAIL rst_abort: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               busy, done, HiOut, LoOut);
    end
    @(negedge clk);
    rst = 1'b0;
    waitDone(busyCnt, doneAt);
    total++;
    if (doneAt != 0 || busyCnt != 0) begin
      bad++;
      $display("FAIL rst_no_done: done_at=%0d busy=%0d want 0 0", doneAt, busyCnt);
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_ops();
    test_ignore_busy_start();
    test_back_to_back();
    test_hilo_write();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
